rf_write_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters.
- Port A is the in-order writeback stage: one write per cycle, stallable via a_stall.
- Port B is a long-latency unit (divider, late load return) using a valid/ready handshake, buffered in a small in-order FIFO.
- The block enforces write-after-write ordering, drops x0 writes, and bounds B starvation. Its registered outputs drive the regfile wr_* inputs directly.

---
 rtl/rf_write_arbiter_if.sv | 29 ++
 rtl/rf_write_arbiter.sv | 125 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Bundle of the writeback (A), long-latency (B) and regfile write-port signals
// shared between the requesters (master) and rf_write_arbiter (slave).
interface rf_write_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_stall;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              flush;
    logic              wr_enable;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, flush,
        input  a_stall, b_ready, wr_enable, wr_addr, wr_data
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, flush,
        output a_stall, b_ready, wr_enable, wr_addr, wr_data
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single regfile write port between the in-order writeback stage
// and a FIFO-buffered long-latency unit, with WAW kill, x0 drop and anti-starvation.
module rf_write_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic             clk,
    input logic             reset,
    rf_write_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_W-1:0]     fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_kill;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [SC_W-1:0]       starve_cnt;

    logic              fifo_nonempty;
    logic              force_b;
    logic              grant_a;
    logic              grant_b;
    logic              b_ready_int;
    logic              push;
    logic              grant_en;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;

    logic              wr_enable_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    // B wins over A only once the starvation counter saturates; otherwise A has priority.
    always_comb begin
        fifo_nonempty = (count != '0);
        force_b       = fifo_nonempty && (starve_cnt == SC_W'(STARVE_LIMIT));
        grant_a       = bus.a_valid && !force_b;
        grant_b       = fifo_nonempty && !grant_a;
        b_ready_int   = (count < CNT_W'(FIFO_DEPTH)) && !bus.flush;
        push          = bus.b_valid && b_ready_int;
        grant_en      = 1'b0;
        grant_addr    = bus.a_addr;
        grant_data    = bus.a_data;
        if (grant_a) begin
            grant_en = (bus.a_addr != '0);
        end else if (grant_b) begin
            grant_addr = fifo_addr[rd_ptr];
            grant_data = fifo_data[rd_ptr];
            grant_en   = (fifo_addr[rd_ptr] != '0) && !fifo_kill[rd_ptr];
        end
    end

    assign bus.a_stall   = bus.a_valid && !grant_a;
    assign bus.b_ready   = b_ready_int;
    assign bus.wr_enable = wr_enable_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.b_addr;
            fifo_data[wr_ptr] <= bus.b_data;
        end
    end

    // Flush drops queued B results, but the grant made in the same cycle still commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fifo_kill   <= '0;
            starve_cnt  <= '0;
            wr_enable_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_enable_q <= grant_en;
            if (grant_a || grant_b) begin
                wr_addr_q <= grant_addr;
                wr_data_q <= grant_data;
            end

            if (grant_b || !fifo_nonempty) begin
                starve_cnt <= '0;
            end else if (grant_a && (starve_cnt != SC_W'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end

            // A younger A write to the same register makes older queued B results dead.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (grant_a && (bus.a_addr != '0) && (fifo_addr[i] == bus.a_addr)) begin
                    fifo_kill[i] <= 1'b1;
                end
            end
            if (push) begin
                fifo_kill[wr_ptr] <= 1'b0;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (grant_b) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push, grant_b})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (bus.flush) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
                fifo_kill  <= '0;
                starve_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Random plus directed bench for rf_write_arbiter, checked against a queue-based
// model of the arbitration rules.
module tb_rf_write_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        bit          killed;
    } entry_t;

    logic clk;
    logic reset;

    rf_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) ifc ();

    rf_write_arbiter #(
        .ADDR_W(5), .DATA_W(32), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int numChecks = 0;
    int numFails  = 0;

    entry_t      q[$];
    int          starve;
    logic        expWrEn;
    logic [4:0]  expWrAddr;
    logic [31:0] expWrData;
    logic        lastStall;
    logic        lastBHold;

    logic        obsStall, obsReady, obsWrEn;
    logic [4:0]  obsWrAddr;
    logic [31:0] obsWrData;

    logic        curRst, curAv, curBv, curFl;
    logic [4:0]  curAa, curBa;
    logic [31:0] curAd, curBd;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, then advance the model.
    task automatic applyStimulus(input logic rst, input logic av, input logic [4:0] aa,
                                 input logic [31:0] ad, input logic bv, input logic [4:0] ba,
                                 input logic [31:0] bd, input logic fl);
        logic   nonEmpty, expReady, expStall, grantA, grantB;
        entry_t head;
        @(negedge clk);
        reset       = rst;
        ifc.a_valid = av;
        ifc.a_addr  = aa;
        ifc.a_data  = ad;
        ifc.b_valid = bv;
        ifc.b_addr  = ba;
        ifc.b_data  = bd;
        ifc.flush   = fl;
        #1;
        nonEmpty = (q.size() > 0);
        expReady = (q.size() < DEPTH) && !fl;
        grantB   = nonEmpty && ((starve == LIMIT) || !av);
        grantA   = av && !grantB;
        expStall = av && !grantA;

        checkOutput("a_stall", 32'(ifc.a_stall), 32'(expStall));
        checkOutput("b_ready", 32'(ifc.b_ready), 32'(expReady));
        checkOutput("wr_enable", 32'(ifc.wr_enable), 32'(expWrEn));
        checkOutput("wr_addr", 32'(ifc.wr_addr), 32'(expWrAddr));
        checkOutput("wr_data", ifc.wr_data, expWrData);
        obsStall  = ifc.a_stall;
        obsReady  = ifc.b_ready;
        obsWrEn   = ifc.wr_enable;
        obsWrAddr = ifc.wr_addr;
        obsWrData = ifc.wr_data;
        lastStall = expStall;
        lastBHold = bv && !expReady;

        if (rst) begin
            q.delete();
            starve    = 0;
            expWrEn   = 1'b0;
            expWrAddr = '0;
            expWrData = '0;
        end else begin
            if (grantA) begin
                expWrEn   = (aa != 0);
                expWrAddr = aa;
                expWrData = ad;
                if (aa != 0) begin
                    foreach (q[i]) if (q[i].addr == aa) q[i].killed = 1'b1;
                end
            end else if (grantB) begin
                head      = q.pop_front();
                expWrEn   = (head.addr != 0) && !head.killed;
                expWrAddr = head.addr;
                expWrData = head.data;
            end else begin
                expWrEn = 1'b0;
            end
            starve = (nonEmpty && grantA) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
            if (bv && expReady) q.push_back('{addr: ba, data: bd, killed: 1'b0});
            if (fl) begin
                q.delete();
                starve = 0;
            end
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    initial begin
        reset       = 1'b1;
        ifc.a_valid = 1'b0;
        ifc.a_addr  = '0;
        ifc.a_data  = '0;
        ifc.b_valid = 1'b0;
        ifc.b_addr  = '0;
        ifc.b_data  = '0;
        ifc.flush   = 1'b0;
        q.delete();
        starve    = 0;
        expWrEn   = 1'b0;
        expWrAddr = '0;
        expWrData = '0;
        lastStall = 1'b0;
        lastBHold = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        idleCycle();
        checkOutput("rst_b_ready", 32'(obsReady), 32'd1);
        checkOutput("rst_wr_en", 32'(obsWrEn), 32'd0);

        // A only
        applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("a_only_stall", 32'(obsStall), 32'd0);
        idleCycle();
        checkOutput("a_only_en", 32'(obsWrEn), 32'd1);
        checkOutput("a_only_addr", 32'(obsWrAddr), 32'd5);
        checkOutput("a_only_data", obsWrData, 32'hDEAD_BEEF);

        // B only
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234, 1'b0);
        checkOutput("b_only_ready", 32'(obsReady), 32'd1);
        idleCycle();
        idleCycle();
        checkOutput("b_only_en", 32'(obsWrEn), 32'd1);
        checkOutput("b_only_addr", 32'(obsWrAddr), 32'd7);

        // Starvation: B entry 9 behind continuous A traffic
        applyStimulus(1'b0, 1'b1, 5'd10, 32'h10, 1'b1, 5'd9, 32'h99, 1'b0);
        for (int i = 0; i < LIMIT; i++) begin
            applyStimulus(1'b0, 1'b1, 5'(11 + i), 32'(i), 1'b0, 5'd0, 32'd0, 1'b0);
            checkOutput("starve_a_run", 32'(obsStall), 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 5'd20, 32'h20, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("starve_forced", 32'(obsStall), 32'd1);
        applyStimulus(1'b0, 1'b1, 5'd20, 32'h20, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("starve_b_addr", 32'(obsWrAddr), 32'd9);
        checkOutput("starve_release", 32'(obsStall), 32'd0);
        idleCycle();

        // WAW kill and x0 drop
        applyStimulus(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd3, 32'h33, 1'b0);
        applyStimulus(1'b0, 1'b1, 5'd3, 32'hA3, 1'b0, 5'd0, 32'd0, 1'b0);
        idleCycle();
        idleCycle();
        checkOutput("waw_killed_en", 32'(obsWrEn), 32'd0);
        checkOutput("waw_killed_addr", 32'(obsWrAddr), 32'd3);
        applyStimulus(1'b0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 1'b0);
        idleCycle();
        checkOutput("x0_en", 32'(obsWrEn), 32'd0);

        // Full then flush alongside an A write
        applyStimulus(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd11, 32'hB1, 1'b0);
        applyStimulus(1'b0, 1'b1, 5'd2, 32'h2, 1'b1, 5'd12, 32'hB2, 1'b0);
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h3, 1'b1, 5'd13, 32'hB3, 1'b0);
        checkOutput("full_ready", 32'(obsReady), 32'd0);
        applyStimulus(1'b0, 1'b1, 5'd4, 32'h4, 1'b0, 5'd0, 32'd0, 1'b1);
        idleCycle();
        checkOutput("flush_a_en", 32'(obsWrEn), 32'd1);
        checkOutput("flush_a_addr", 32'(obsWrAddr), 32'd4);
        checkOutput("flush_ready", 32'(obsReady), 32'd1);
        idleCycle();
        checkOutput("flush_no_b", 32'(obsWrEn), 32'd0);

        // Reset with two entries queued
        applyStimulus(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd14, 32'hC1, 1'b0);
        applyStimulus(1'b0, 1'b1, 5'd2, 32'h2, 1'b1, 5'd15, 32'hC2, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        idleCycle();
        checkOutput("reset_en", 32'(obsWrEn), 32'd0);
        checkOutput("reset_ready", 32'(obsReady), 32'd1);
        idleCycle();
        checkOutput("reset_no_b", 32'(obsWrEn), 32'd0);

        // Randomized traffic; stalled A and refused B hold their requests stable
        lastStall = 1'b0;
        lastBHold = 1'b0;
        curAv = 1'b0; curAa = '0; curAd = '0;
        curBv = 1'b0; curBa = '0; curBd = '0;
        for (int n = 0; n < 2000; n++) begin
            curRst = ($urandom_range(0, 99) == 0);
            curFl  = ($urandom_range(0, 19) == 0);
            if (!lastStall) begin
                curAv = ($urandom_range(0, 99) < 65);
                curAa = 5'($urandom_range(0, 7));
                curAd = $urandom;
            end
            if (!lastBHold) begin
                curBv = ($urandom_range(0, 99) < 45);
                curBa = 5'($urandom_range(0, 7));
                curBd = $urandom;
            end
            applyStimulus(curRst, curAv, curAa, curAd, curBv, curBa, curBd, curFl);
        end
        idleCycle();
        idleCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end
endmodule
